// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and receiver state type, also used by
// the display generator so both ends agree on where sync edges belong.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_TOTAL      = 800;
    localparam int H_SYNC_START = 658;
    localparam int V_ACTIVE     = 480;
    localparam int V_TOTAL      = 525;
    localparam int V_SYNC_START = 492;
    localparam int LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        V_ALIGN = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

    // Position counter step with wrap after the last column/line.
    function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
        return (val == last) ? 10'd0 : val + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Falling-edge detector for an active-low sync line. The history register
// comes out of reset high, but a separate arm flag keeps a line that is
// already low at reset release from being reported as a fresh edge: an edge
// is only reported once the line has been seen high after reset.
module vga_edge_detect (
    input  logic clk25,
    input  logic rst,
    input  logic sig_i,
    output logic fall_o
);

    logic prev_q;
    logic armed_q;

    // Sample history and arm once the line has been observed high.
    always_ff @(posedge clk25) begin
        if (rst) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= armed_q | sig_i;
        end
    end

    assign fall_o = ~sig_i & prev_q & armed_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel position from hSync/vSync of a same-clock timing generator
// and qualifies the incoming colour stream once the timing is locked.
//
// state   | meaning
// SEARCH  | no hSync seen yet; position outputs held at 0
// V_ALIGN | column tracked, counting correctly placed vSync edges
// LOCKED  | column and line confirmed; pixels qualified
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int P_H_ACTIVE     = H_ACTIVE,
    parameter int P_H_TOTAL      = H_TOTAL,
    parameter int P_H_SYNC_START = H_SYNC_START,
    parameter int P_V_ACTIVE     = V_ACTIVE,
    parameter int P_V_TOTAL      = V_TOTAL,
    parameter int P_V_SYNC_START = V_SYNC_START,
    parameter int P_LOCK_FRAMES  = LOCK_FRAMES
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rbg,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic [11:0] pixel_rbg,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_error
);

    localparam logic [9:0] H_LAST = 10'(P_H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(P_V_TOTAL - 1);
    localparam logic [9:0] H_SYNC = 10'(P_H_SYNC_START);
    localparam logic [9:0] V_SYNC = 10'(P_V_SYNC_START);
    localparam logic [9:0] H_ACT  = 10'(P_H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(P_V_ACTIVE);
    localparam int         FC_W   = $clog2(P_LOCK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LOCK = FC_W'(P_LOCK_FRAMES);

    logic h_fall;
    logic v_fall;

    rx_state_e       state_q, state_d;
    logic [9:0]      h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic [FC_W-1:0] fc_q, fc_d;

    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [11:0] pixel_rbg_q, pixel_rbg_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_error_q, sync_error_d;

    logic       tracking;
    logic       at_eol;
    logic       h_err;
    logic       v_load;
    logic       v_err;
    logic       any_err;
    logic [9:0] cur_h;
    logic [9:0] cur_v;

    vga_edge_detect u_h_edge (
        .clk25  (clk25),
        .rst    (rst),
        .sig_i  (hSync),
        .fall_o (h_fall)
    );

    vga_edge_detect u_v_edge (
        .clk25  (clk25),
        .rst    (rst),
        .sig_i  (vSync),
        .fall_o (v_fall)
    );

    // Next state, position counters and registered output values.
    // cur_h/cur_v are the position of the sample taken on this edge after
    // any sync-driven reload; the counters then advance from there.
    always_comb begin
        tracking = (state_q != SEARCH);
        at_eol   = (h_q == H_LAST);
        h_err    = tracking && h_fall && (h_q != H_SYNC);
        v_load   = tracking && v_fall && at_eol;
        v_err    = tracking && v_fall && (!at_eol || ((state_q == LOCKED) && (v_q != V_SYNC)));
        any_err  = h_err || v_err;
        cur_h    = h_fall ? H_SYNC : h_q;
        cur_v    = v_load ? V_SYNC : v_q;

        // A vSync edge on an already-matching line is a confirmation;
        // on any other line it restarts the count at this edge.
        fc_d = fc_q;
        if (any_err) begin
            fc_d = '0;
        end else if (v_load) begin
            if (v_q == V_SYNC) begin
                fc_d = (fc_q == FC_LOCK) ? fc_q : fc_q + 1'b1;
            end else begin
                fc_d = FC_W'(1);
            end
        end

        state_d = state_q;
        case (state_q)
            SEARCH: begin
                if (h_fall) state_d = V_ALIGN;
            end
            V_ALIGN, LOCKED: begin
                if (any_err)              state_d = V_ALIGN;
                else if (fc_d == FC_LOCK) state_d = LOCKED;
            end
            default: state_d = SEARCH;
        endcase

        h_d = 10'd0;
        v_d = 10'd0;
        if (state_d != SEARCH) begin
            h_d = wrap_inc(cur_h, H_LAST);
            v_d = (cur_h == H_LAST) ? wrap_inc(cur_v, V_LAST) : cur_v;
        end

        pixel_x_d     = (state_d == SEARCH) ? 10'd0 : cur_h;
        pixel_y_d     = (state_d == SEARCH) ? 10'd0 : cur_v;
        pixel_valid_d = (state_d == LOCKED) && (cur_h < H_ACT) && (cur_v < V_ACT);
        pixel_rbg_d   = pixel_valid_d ? rbg : 12'd0;
        locked_d      = (state_d == LOCKED);
        frame_start_d = (state_d == LOCKED) && (cur_h == 10'd0) && (cur_v == 10'd0);
        sync_error_d  = any_err;
    end

    // FSM, counters and output registers; reset wins over any partial frame.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q       <= SEARCH;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            fc_q          <= '0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            pixel_valid_q <= 1'b0;
            pixel_rbg_q   <= 12'd0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            fc_q          <= fc_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_rbg_q   <= pixel_rbg_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_rbg   = pixel_rbg_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a scaled-down raster so several frames
// fit in a short run. The reference tracks the receiver's belief as one
// linear position within the frame and applies the sync placement rules.
module tb_vga_sync_receiver;

    localparam int HT  = 24;
    localparam int HA  = 16;
    localparam int HSS = 18;
    localparam int HSW = 4;
    localparam int VT  = 14;
    localparam int VA  = 10;
    localparam int VSS = 11;
    localparam int LF  = 2;
    localparam int FT  = HT * VT;
    localparam int VF_POS = VSS * HT + HT - 1;

    logic        clk25 = 1'b0;
    logic        rst   = 1'b1;
    logic        hSync = 1'b1;
    logic        vSync = 1'b1;
    logic [11:0] rbg   = 12'd0;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic [11:0] pixel_rbg;
    logic        locked;
    logic        frame_start;
    logic        sync_error;

    vga_sync_receiver #(
        .P_H_ACTIVE     (HA),
        .P_H_TOTAL      (HT),
        .P_H_SYNC_START (HSS),
        .P_V_ACTIVE     (VA),
        .P_V_TOTAL      (VT),
        .P_V_SYNC_START (VSS),
        .P_LOCK_FRAMES  (LF)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .hSync       (hSync),
        .vSync       (vSync),
        .rbg         (rbg),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .pixel_rbg   (pixel_rbg),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_error  (sync_error)
    );

    always #20 clk25 = ~clk25;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // generator
    int gp = 0;
    int stall_left = 0;
    bit glitch_h = 0;
    bit glitch_v = 0;

    // reference model
    bit m_trk, m_lk, m_hprev, m_harm, m_vprev, m_varm, m_vf;
    int m_cnt, m_pos;
    int e_x, e_y, e_val, e_rbg, e_lk, e_fs, e_err;

    // observations
    int samp = 0;
    int vf_cnt = 0;
    int err_cnt = 0;
    int fs_cnt = 0;
    int fs_last = -1;
    int fs_gap = -1;
    int lock_rise_samp = -1;
    int lock_rise_vf = -1;
    bit was_locked = 0;

    task automatic drive();
        int gh, lin;
        gh    = gp % HT;
        lin   = (gp - VF_POS + FT) % FT;
        hSync = !((gh >= HSS && gh < HSS + HSW) || glitch_h);
        vSync = !((lin < 2 * HT) || glitch_v);
        rbg   = 12'($urandom);
    endtask

    task automatic model_step();
        bit hf, vf, vok, err;
        int cur, ph, pv;
        if (rst) begin
            m_trk = 0; m_lk = 0; m_cnt = 0; m_pos = 0;
            m_hprev = 1; m_harm = 0; m_vprev = 1; m_varm = 0; m_vf = 0;
            e_x = 0; e_y = 0; e_val = 0; e_rbg = 0; e_lk = 0; e_fs = 0; e_err = 0;
            return;
        end
        hf = !hSync && m_hprev && m_harm;
        vf = !vSync && m_vprev && m_varm;
        m_harm = m_harm | hSync; m_hprev = hSync;
        m_varm = m_varm | vSync; m_vprev = vSync;
        m_vf = vf;
        err = 0;
        cur = 0;
        if (!m_trk) begin
            if (hf) begin
                m_trk = 1;
                cur = HSS;
            end
        end else begin
            ph  = m_pos % HT;
            pv  = m_pos / HT;
            cur = m_pos;
            vok = vf && (ph == HT - 1);
            err = (hf && ph != HSS) || (vf && !vok) || (vok && m_lk && pv != VSS);
            if (hf)  cur = pv * HT + HSS;
            if (vok) cur = VSS * HT + cur % HT;
            if (err) begin
                m_cnt = 0;
                m_lk  = 0;
            end else if (vok) begin
                m_cnt = (pv == VSS) ? ((m_cnt + 1 > LF) ? LF : m_cnt + 1) : 1;
                if (m_cnt >= LF) m_lk = 1;
            end
        end
        e_x   = m_trk ? cur % HT : 0;
        e_y   = m_trk ? cur / HT : 0;
        e_val = (m_lk && (cur % HT) < HA && (cur / HT) < VA) ? 1 : 0;
        e_rbg = e_val ? int'(rbg) : 0;
        e_lk  = m_lk;
        e_fs  = (m_lk && cur == 0) ? 1 : 0;
        e_err = err;
        m_pos = m_trk ? (cur + 1) % FT : 0;
    endtask

    task automatic cycle(input bit adv);
        model_step();
        @(posedge clk25);
        #1;
        check_eq("pixel_x", pixel_x, e_x);
        check_eq("pixel_y", pixel_y, e_y);
        check_eq("pixel_valid", pixel_valid, e_val);
        check_eq("pixel_rbg", pixel_rbg, e_rbg);
        check_eq("locked", locked, e_lk);
        check_eq("frame_start", frame_start, e_fs);
        check_eq("sync_error", sync_error, e_err);
        if (m_vf) vf_cnt++;
        if (sync_error) err_cnt++;
        if (frame_start) begin
            fs_cnt++;
            if (fs_last >= 0) fs_gap = samp - fs_last;
            fs_last = samp;
        end
        if (locked && !was_locked) begin
            lock_rise_samp = samp;
            lock_rise_vf   = vf_cnt;
        end
        was_locked = locked;
        samp++;
        glitch_h = 0;
        glitch_v = 0;
        if (adv) begin
            if (stall_left > 0) stall_left--;
            else gp = (gp + 1) % FT;
        end
        drive();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 4 * FT; i++) begin
            if (gp == target && stall_left == 0) break;
            cycle(1);
        end
        check_eq("reach_pos", gp, target);
    endtask

    task automatic wait_lock(input string tag);
        for (int i = 0; i < 4 * FT; i++) begin
            if (locked) break;
            cycle(1);
        end
        check_eq(tag, locked, 1);
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int line, col, kind;

        // startup from reset with standard timing
        rst = 1;
        drive();
        repeat (3) cycle(0);
        rst = 0;
        samp = 0; vf_cnt = 0; err_cnt = 0; was_locked = 0; lock_rise_samp = -1;
        repeat (2 * FT + 40) cycle(1);
        check_eq("lock_rise_samp", lock_rise_samp, FT + VF_POS);
        check_eq("lock_rise_vf", lock_rise_vf, 2);
        check_eq("startup_errors", err_cnt, 0);

        // visible pixel capture
        run_until(5 * HT + 10);
        rbg = 12'hABC;
        cycle(1);
        check_eq("vis_x", pixel_x, 10);
        check_eq("vis_y", pixel_y, 5);
        check_eq("vis_valid", pixel_valid, 1);
        check_eq("vis_rbg", pixel_rbg, 12'hABC);

        // horizontal blanking column
        run_until(5 * HT + 20);
        rbg = 12'hFFF;
        cycle(1);
        check_eq("blank_x", pixel_x, 20);
        check_eq("blank_valid", pixel_valid, 0);
        check_eq("blank_rbg", pixel_rbg, 0);

        // frame_start rate while locked
        run_until(1);
        fs_cnt = 0; fs_last = -1; fs_gap = -1; err_cnt = 0;
        repeat (3 * FT) cycle(1);
        check_eq("fs_count", fs_cnt, 3);
        check_eq("fs_gap", fs_gap, FT);
        check_eq("fs_errors", err_cnt, 0);

        // hSync edge delayed 3 clocks: one error, relock after 2 vSync edges
        line = $urandom_range(0, VA - 1);
        run_until(line * HT + 10);
        err_cnt = 0; vf_cnt = 0; lock_rise_vf = -1;
        stall_left = 3;
        repeat (3 * FT) cycle(1);
        check_eq("slip_errors", err_cnt, 1);
        check_eq("slip_relock_vf", lock_rise_vf, 2);
        check_eq("slip_locked", locked, 1);

        // simultaneous misplaced hSync and vSync edges
        run_until(3 * HT + 5);
        glitch_h = 1;
        glitch_v = 1;
        drive();
        cycle(1);
        check_eq("dual_err_pulse", sync_error, 1);
        check_eq("dual_err_unlock", locked, 0);
        cycle(1);
        check_eq("dual_err_single", sync_error, 0);
        wait_lock("dual_relock");

        // one-cycle reset mid-line
        line = $urandom_range(1, VA - 1);
        col  = $urandom_range(0, HT - 1);
        run_until(line * HT + col);
        rst = 1;
        cycle(1);
        check_eq("rst_xy", {pixel_x, pixel_y}, 0);
        check_eq("rst_rest", {pixel_valid, pixel_rbg, locked, frame_start, sync_error}, 0);
        rst = 0;
        vf_cnt = 0; lock_rise_vf = -1; err_cnt = 0;
        repeat (3 * FT) cycle(1);
        check_eq("rst_relock_vf", lock_rise_vf, 2);
        check_eq("rst_errors", err_cnt, 0);

        // random disturbances against the reference
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(20, 400)) cycle(1);
            kind = $urandom_range(0, 4);
            case (kind)
                0: stall_left = $urandom_range(1, 5);
                1: begin glitch_h = 1; drive(); end
                2: begin glitch_v = 1; drive(); end
                3: begin glitch_h = 1; glitch_v = 1; drive(); end
                default: begin
                    rst = 1;
                    cycle(1);
                    rst = 0;
                end
            endcase
        end
        repeat (3 * FT) cycle(1);
        check_eq("final_locked", locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
